regfile_read_port_unit: RTL and testbench

//   Read side of the general-register file: 32 x 32-bit GR storage, written through the

---
 rtl/regfile_pkg.sv | 14 +
 rtl/binaryDecoder.sv | 14 +
 rtl/reg_scoreboard.sv | 41 ++++
 rtl/regfile_read_port_unit.sv | 95 +++++++++
 tb/tb_regfile_read_port_unit.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the general-register file.
// Imported by the decoder, scoreboard and read-port top level.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] gr_addr_t;
  typedef logic [DATA_W-1:0] gr_data_t;

  localparam gr_addr_t GR_ZERO = 5'd0;

endpackage

// File: rtl/binaryDecoder.sv
// 5-to-32 one-hot decoder with enable.
// Drives the per-register write enables.
module binaryDecoder (
  input  logic [4:0]  D,
  input  logic        E,
  output logic [31:0] O
);

  always_comb begin
    O    = '0;
    O[D] = E;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write busy bits with set-over-clear priority.
// Reports whether each read operand may proceed this cycle.
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     we,
  input  gr_addr_t rw,
  input  logic     sb_set,
  input  gr_addr_t sb_addr,
  input  gr_addr_t ra,
  input  gr_addr_t rb,
  output logic     opa_ok,
  output logic     opb_ok
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (we)
      busy_d[rw] = 1'b0;
    // A newer producer outranks the write that retires an older one
    if (sb_set)
      busy_d[sb_addr] = 1'b1;
    busy_d[GR_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign opa_ok = (ra == GR_ZERO) | ~busy_q[ra] | (we & (rw == ra));
  assign opb_ok = (rb == GR_ZERO) | ~busy_q[rb] | (we & (rw == rb));

endmodule

// File: rtl/regfile_read_port_unit.sv
// 32x32 general-register file with two registered read ports,
// write-first bypass and a pending-write scoreboard; GR0 reads zero.
module regfile_read_port_unit
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     WE,
  input  gr_addr_t RW,
  input  gr_data_t PW,
  input  logic     SB_SET,
  input  gr_addr_t SB_ADDR,
  input  logic     RE,
  input  gr_addr_t RA,
  input  gr_addr_t RB,
  output logic     STALL,
  output logic     RVALID,
  output gr_data_t PA,
  output gr_data_t PB
);

  gr_data_t         gr_q [NREGS];
  gr_data_t         gr_d [NREGS];
  logic [NREGS-1:0] wr_en;
  logic             opa_ok;
  logic             opb_ok;
  logic             accept;
  logic             rvalid_q, rvalid_d;
  gr_data_t         pa_q, pa_d;
  gr_data_t         pb_q, pb_d;

  binaryDecoder u_wdec (
    .D (RW),
    .E (WE & (RW != GR_ZERO)),
    .O (wr_en)
  );

  reg_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .we      (WE),
    .rw      (RW),
    .sb_set  (SB_SET),
    .sb_addr (SB_ADDR),
    .ra      (RA),
    .rb      (RB),
    .opa_ok  (opa_ok),
    .opb_ok  (opb_ok)
  );

  function automatic gr_data_t rd_mux(input gr_addr_t a);
    if (a == GR_ZERO)
      return '0;
    else if (WE && (RW == a))
      return PW;
    else
      return gr_q[a];
  endfunction

  always_comb begin
    for (int i = 0; i < NREGS; i++)
      gr_d[i] = wr_en[i] ? PW : gr_q[i];
  end

  // Reset forces a clean pipeline, so no stall is reported through it
  assign STALL  = ~reset & RE & ~(opa_ok & opb_ok);
  assign accept = RE & ~STALL;

  always_comb begin
    rvalid_d = accept;
    pa_d     = accept ? rd_mux(RA) : pa_q;
    pb_d     = accept ? rd_mux(RB) : pb_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        gr_q[i] <= '0;
      rvalid_q <= 1'b0;
      pa_q     <= '0;
      pb_q     <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        gr_q[i] <= gr_d[i];
      rvalid_q <= rvalid_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
    end
  end

  assign RVALID = rvalid_q;
  assign PA     = pa_q;
  assign PB     = pb_q;

endmodule

// File: tb/tb_regfile_read_port_unit.sv
// Bench for regfile_read_port_unit: vector table, scoreboard queue
// and a register-image sweep across all 31 writable registers.
module tb_regfile_read_port_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [4:0]  RW;
  logic [31:0] PW;
  logic        SB_SET;
  logic [4:0]  SB_ADDR;
  logic        RE;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic        STALL;
  logic        RVALID;
  logic [31:0] PA;
  logic [31:0] PB;

  regfile_read_port_unit dut (
    .clk     (clk),
    .reset   (reset),
    .WE      (WE),
    .RW      (RW),
    .PW      (PW),
    .SB_SET  (SB_SET),
    .SB_ADDR (SB_ADDR),
    .RE      (RE),
    .RA      (RA),
    .RB      (RB),
    .STALL   (STALL),
    .RVALID  (RVALID),
    .PA      (PA),
    .PB      (PB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  rw;
    logic [31:0] pw;
    logic        sb;
    logic [4:0]  sba;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        stall;
    logic        valid;
    logic [31:0] pa;
    logic [31:0] pb;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pa;
    logic [31:0] pb;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_pa = '0;
  logic [31:0] last_pb = '0;
  logic [31:0] img [32];

  function automatic vec_t mk(
    input logic rst, input logic we, input logic [4:0] rw,
    input logic [31:0] pw, input logic sb, input logic [4:0] sba,
    input logic re, input logic [4:0] ra, input logic [4:0] rb,
    input logic stall, input logic valid,
    input logic [31:0] pa, input logic [31:0] pb);
    vec_t v;
    v.rst = rst; v.we = we; v.rw = rw; v.pw = pw;
    v.sb = sb; v.sba = sba; v.re = re; v.ra = ra; v.rb = rb;
    v.stall = stall; v.valid = valid; v.pa = pa; v.pb = pb;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    exp_t e, g;
    @(negedge clk);
    reset = v.rst; WE = v.we; RW = v.rw; PW = v.pw;
    SB_SET = v.sb; SB_ADDR = v.sba;
    RE = v.re; RA = v.ra; RB = v.rb;
    #1;
    n_vec++;
    if (STALL !== v.stall) begin
      n_err++;
      $display("FAIL %s stall: got %b want %b", tag, STALL, v.stall);
    end
    // Unaccepted reads hold the previous operands; reset zeroes them
    e.valid = v.valid;
    if (v.rst) begin
      e.pa = '0; e.pb = '0;
    end else if (v.valid) begin
      e.pa = v.pa; e.pb = v.pb;
    end else begin
      e.pa = last_pa; e.pb = last_pb;
    end
    last_pa = e.pa;
    last_pb = e.pb;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    if (RVALID !== g.valid || PA !== g.pa || PB !== g.pb) begin
      n_err++;
      $display("FAIL %s out: got v=%b pa=%h pb=%h want v=%b pa=%h pb=%h",
               tag, RVALID, PA, PB, g.valid, g.pa, g.pb);
    end
  endtask

  vec_t tbl [19];

  initial begin
    reset = 1'b1; WE = 0; RW = 0; PW = 0; SB_SET = 0; SB_ADDR = 0;
    RE = 0; RA = 0; RB = 0;

    tbl[0]  = mk(1,0,0,0,          0,0, 0,0,0, 0,0,0,0);
    tbl[1]  = mk(1,0,0,0,          0,0, 0,0,0, 0,0,0,0);
    tbl[2]  = mk(0,0,0,0,          0,0, 1,3,7, 0,1,0,0);
    tbl[3]  = mk(0,1,5,32'hDEADBEEF,0,0, 0,0,0, 0,0,0,0);
    tbl[4]  = mk(0,0,0,0,          0,0, 1,5,0, 0,1,32'hDEADBEEF,0);
    tbl[5]  = mk(0,1,0,32'hFFFFFFFF,0,0, 0,0,0, 0,0,0,0);
    tbl[6]  = mk(0,0,0,0,          0,0, 1,0,5, 0,1,0,32'hDEADBEEF);
    tbl[7]  = mk(0,1,9,32'h12345678,0,0, 1,9,9, 0,1,32'h12345678,32'h12345678);
    tbl[8]  = mk(0,0,0,0,          1,4, 0,0,0, 0,0,0,0);
    tbl[9]  = mk(0,0,0,0,          0,0, 1,4,9, 1,0,0,0);
    tbl[10] = mk(0,1,4,32'hA5A5A5A5,0,0, 1,4,9, 0,1,32'hA5A5A5A5,32'h12345678);
    tbl[11] = mk(0,0,0,0,          0,0, 1,4,0, 0,1,32'hA5A5A5A5,0);
    tbl[12] = mk(0,1,6,32'h00000066,1,6, 0,0,0, 0,0,0,0);
    tbl[13] = mk(0,0,0,0,          0,0, 1,0,6, 1,0,0,0);
    tbl[14] = mk(0,0,0,0,          0,0, 1,6,6, 1,0,0,0);
    tbl[15] = mk(0,0,0,0,          1,7, 1,7,7, 0,1,0,0);
    tbl[16] = mk(0,0,0,0,          0,0, 1,7,0, 1,0,0,0);
    tbl[17] = mk(0,0,0,0,          1,0, 0,0,0, 0,0,0,0);
    tbl[18] = mk(0,0,0,0,          0,0, 1,0,0, 0,1,0,0);

    for (int i = 0; i < 19; i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Reset on top of an acceptable read drops it and clears busy/GRs
    apply(mk(1,0,0,0, 0,0, 1,9,5, 0,0,0,0), "rst_read");
    apply(mk(0,0,0,0, 0,0, 1,6,7, 0,1,0,0), "post_rst_busy");
    apply(mk(0,0,0,0, 0,0, 1,9,5, 0,1,0,0), "post_rst_gr");

    // Fill every register, then read it back against the image
    img[0] = '0;
    for (int i = 1; i < 32; i++) begin
      img[i] = $urandom;
      apply(mk(0,1,5'(i),img[i], 0,0, 0,0,0, 0,0,0,0), $sformatf("wr%0d", i));
    end
    for (int i = 0; i < 32; i++)
      apply(mk(0,0,0,0, 0,0, 1,5'(i),5'(31-i), 0,1,img[i],img[31-i]),
            $sformatf("rd%0d", i));

    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL sbq_drain: got %0d entries want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
